rom_scan_ctrl: RTL and testbench

ROM_SCAN_CTRL -- requirements
Module: rom_scan_ctrl

---
 rtl/rom_scan_ctrl_if.sv | 31 +++
 rtl/rom_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_rom_scan_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_scan_ctrl_if.sv
// Request, status and ROM bus bundle for rom_scan_ctrl.
// master issues requests and returns ROM data; slave is the controller.
interface rom_scan_ctrl_if #(
  parameter int DIV_W = 16
);
  logic             start;
  logic             stop;
  logic             dir;
  logic             loop;
  logic [DIV_W-1:0] period;
  logic [2:0]       rom_addr;
  logic [7:0]       rom_dout;
  logic [7:0]       pattern;
  logic             pattern_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, dir, loop,
    output period, rom_dout,
    input  rom_addr, pattern,
    input  pattern_valid, busy, done
  );

  modport slave (
    input  start, stop, dir, loop,
    input  period, rom_dout,
    output rom_addr, pattern,
    output pattern_valid, busy, done
  );
endinterface

// File: rtl/rom_scan_ctrl.sv
// Sweeps an 8x8 synchronous ROM and holds each word for a period.
// ROM_SCAN_PINGPONG_EN selects a bouncing sweep (0..7..0) instead of 0..7.
module rom_scan_ctrl #(
  parameter int DIV_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  rom_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPTURE,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       addr_q, addr_d;
  logic [7:0]       pat_q, pat_d;
  logic             pv_q, pv_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  logic [2:0] first_a;
  logic [2:0] last_a;
  logic [2:0] fwd_a;
  logic [2:0] adv_a;
  logic [2:0] rest_a;
  logic       end_sweep;

  assign first_a = dir_q ? 3'd7 : 3'd0;
  assign last_a  = ~first_a;
  assign fwd_a   = dir_q ? addr_q - 3'd1
                         : addr_q + 3'd1;

`ifdef ROM_SCAN_PINGPONG_EN
  logic       back_q, back_d;
  logic [2:0] bwd_a;
  logic       turn;

  assign bwd_a     = dir_q ? addr_q + 3'd1
                           : addr_q - 3'd1;
  assign turn      = !back_q && (addr_q == last_a);
  assign end_sweep = back_q && (addr_q == first_a);
  // a looping bounce leaves the start point without revisiting it
  assign rest_a    = fwd_a;
  assign adv_a     = (back_q || turn) ? bwd_a : fwd_a;
`else
  assign end_sweep = (addr_q == last_a);
  assign rest_a    = first_a;
  assign adv_a     = fwd_a;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pat_d   = pat_q;
    pv_d    = 1'b0;
    done_d  = 1'b0;
    dir_d   = dir_q;
    per_d   = per_q;
    cnt_d   = cnt_q;
`ifdef ROM_SCAN_PINGPONG_EN
    back_d  = back_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          dir_d   = bus.dir;
          per_d   = (bus.period == '0) ? DIV_W'(1)
                                       : bus.period;
          addr_d  = bus.dir ? 3'd7 : 3'd0;
          state_d = FETCH;
`ifdef ROM_SCAN_PINGPONG_EN
          back_d  = 1'b0;
`endif
        end
      end
      FETCH: begin
        state_d = bus.stop ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          pat_d   = bus.rom_dout;
          pv_d    = 1'b1;
          cnt_d   = per_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_q > DIV_W'(1)) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (end_sweep) begin
          if (bus.loop) begin
            addr_d  = rest_a;
            state_d = FETCH;
`ifdef ROM_SCAN_PINGPONG_EN
            back_d  = 1'b0;
`endif
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          addr_d  = adv_a;
          state_d = FETCH;
`ifdef ROM_SCAN_PINGPONG_EN
          if (turn) back_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 3'd0;
      pat_q   <= 8'd0;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      per_q   <= '0;
      cnt_q   <= '0;
`ifdef ROM_SCAN_PINGPONG_EN
      back_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pat_q   <= pat_d;
      pv_q    <= pv_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
`ifdef ROM_SCAN_PINGPONG_EN
      back_q  <= back_d;
`endif
    end
  end

  assign bus.rom_addr      = addr_q;
  assign bus.pattern       = pat_q;
  assign bus.pattern_valid = pv_q;
  assign bus.done          = done_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Randomized and directed bench for rom_scan_ctrl against a
// step/time model of the scan plus literal sweep expectations.
module tb_rom_scan_ctrl;
  localparam int DIV_W = 16;
`ifdef ROM_SCAN_PINGPONG_EN
  localparam int SW = 15;
`else
  localparam int SW = 8;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_scan_ctrl_if #(.DIV_W(DIV_W)) bus ();

  rom_scan_ctrl #(.DIV_W(DIV_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] rom [8];
  always @(posedge clk) bus.rom_dout <= rom[bus.rom_addr];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 0;

  // model: a scan is a series of steps of len = max(P,1)+2 cycles;
  // cycle t=1 of a step ends with the word captured
  bit       m_act = 0;
  bit       m_dir = 0;
  int       m_k = 0;
  int       m_t = 0;
  int       m_len = 3;
  bit [2:0] m_addr = 0;
  bit [7:0] m_pat = 0;
  bit       m_pv = 0;
  bit       m_done = 0;

  function automatic bit [2:0] seq_addr(bit d, int k);
    int off;
`ifdef ROM_SCAN_PINGPONG_EN
    int m = k % 14;
    off = (m <= 7) ? m : 14 - m;
`else
    off = k % 8;
`endif
    return d ? 3'(7 - off) : 3'(off);
  endfunction

  function automatic bit sweep_end(int k);
`ifdef ROM_SCAN_PINGPONG_EN
    return (k > 0) && (k % 14 == 0);
`else
    return (k % 8) == 7;
`endif
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_pv = 0;
    m_done = 0;
    if (!rst_n) begin
      m_act = 0; m_addr = 0; m_pat = 0;
      m_k = 0; m_t = 0;
    end else if (!m_act) begin
      if (bus.start && !bus.stop) begin
        m_act = 1; m_k = 0; m_t = 0;
        m_dir = bus.dir;
        m_len = ((bus.period == 0) ? 1
                 : int'(bus.period)) + 2;
        m_addr = seq_addr(m_dir, 0);
      end
    end else if (bus.stop) begin
      m_act = 0;
    end else begin
      if (m_t == 1) begin
        m_pat = rom[m_addr];
        m_pv = 1;
      end
      if (m_t == m_len - 1) begin
        if (sweep_end(m_k) && !bus.loop) begin
          m_act = 0;
          m_done = 1;
        end else begin
          m_k++;
          m_t = 0;
          m_addr = seq_addr(m_dir, m_k);
        end
      end else begin
        m_t++;
      end
    end
  end

  logic [7:0] pv_pat [$];
  int         pv_cyc [$];
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic [13:0] got, exp;
      got = {bus.rom_addr, bus.pattern,
             bus.pattern_valid, bus.busy, bus.done};
      exp = {m_addr, m_pat, m_pv, m_act, m_done};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL model cyc=%0d got a=%0d p=%h v=%b b=%b d=%b want a=%0d p=%h v=%b b=%b d=%b",
          cyc, got[13:11], got[10:3], got[2], got[1], got[0],
          exp[13:11], exp[10:3], exp[2], exp[1], exp[0]);
      end
    end
    if (bus.pattern_valid === 1'b1) begin
      pv_pat.push_back(bus.pattern);
      pv_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic check(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pv_pat.delete();
    pv_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic wait_pv(int n, int budget, string name);
    int b = budget;
    while (pv_pat.size() < n && b > 0) begin
      tick();
      b--;
    end
    if (pv_pat.size() < n) check(name, pv_pat.size(), n);
  endtask

  task automatic wait_done(int n, int budget, string name);
    int b = budget;
    while (done_cnt < n && b > 0) begin
      tick();
      b--;
    end
    if (done_cnt < n) check(name, done_cnt, n);
  endtask

  function automatic int pv_at(int i);
    return (i < pv_pat.size()) ? int'(pv_pat[i]) : -1;
  endfunction

  function automatic int gap(int i);
    if (i < 1 || i >= pv_cyc.size()) return -1;
    return pv_cyc[i] - pv_cyc[i-1];
  endfunction

  function automatic int sweep0(int i);
    return (i < 8) ? (1 << i) : (1 << (14 - i));
  endfunction

  function automatic int sweep1(int i);
    return (i < 8) ? (8'h80 >> i) : (8'h80 >> (14 - i));
  endfunction

  initial begin
    int exp33 [10];
    for (int i = 0; i < 8; i++) rom[i] = 8'(1 << i);
    bus.start = 0; bus.stop = 0; bus.dir = 0;
    bus.loop = 0; bus.period = '0;

    tick(); tick();
    chk_en = 1;
    tick();
    check("rst_addr", bus.rom_addr, 0);
    check("rst_pattern", bus.pattern, 0);
    check("rst_flags", {bus.pattern_valid, bus.busy, bus.done}, 0);
    rst_n = 1;
    tick();

    // single sweep upward, period 2
    clr();
    bus.start = 1; bus.dir = 0; bus.period = 2; bus.loop = 0;
    tick();
    bus.start = 0;
    wait_done(1, 300, "sweep_timeout");
    tick();
    check("sweep_count", pv_pat.size(), SW);
    for (int i = 0; i < SW; i++) check("sweep_pat", pv_at(i), sweep0(i));
    for (int i = 1; i < SW; i++) check("sweep_gap", gap(i), 4);
    check("sweep_done", done_cnt, 1);
    check("sweep_busy", bus.busy, 0);

    // looping downward sweep, period 0, stopped after 10 words
    clr();
    for (int i = 0; i < 10; i++)
      exp33[i] = (SW == 8) ? (8'h80 >> (i % 8)) : sweep1(i);
    bus.start = 1; bus.dir = 1; bus.period = 0; bus.loop = 1;
    tick();
    bus.start = 0;
    wait_pv(10, 200, "loop_timeout");
    bus.stop = 1;
    tick();
    bus.stop = 0;
    tick();
    for (int i = 0; i < 10; i++) check("loop_pat", pv_at(i), exp33[i]);
    for (int i = 1; i < 10; i++) check("loop_gap", gap(i), 3);
    check("loop_stop_busy", bus.busy, 0);
    check("loop_hold_pat", bus.pattern, exp33[9]);
    check("loop_no_done", done_cnt, 0);
    check("loop_pv_total", pv_pat.size(), 10);

    // stop while the first fetch is in flight
    clr();
    bus.start = 1; bus.dir = 0; bus.period = 3; bus.loop = 0;
    tick();
    bus.start = 0; bus.stop = 1;
    tick();
    bus.stop = 0;
    check("fetch_stop_busy", bus.busy, 0);
    tick(); tick(); tick();
    check("fetch_stop_pv", pv_pat.size(), 0);

    // start held high; period/dir changes ignored until restart
    clr();
    bus.start = 1; bus.dir = 0; bus.period = 2; bus.loop = 0;
    wait_pv(3, 50, "hold_timeout");
    bus.period = 5; bus.dir = 1;
    wait_done(1, 300, "hold_done_timeout");
    wait_pv(SW + 2, 100, "restart_timeout");
    bus.start = 0;
    for (int i = 0; i < SW; i++) check("hold_pat", pv_at(i), sweep0(i));
    for (int i = 1; i < SW; i++) check("hold_gap", gap(i), 4);
    check("restart_first", pv_at(SW), 8'h80);
    check("restart_gap", gap(SW + 1), 7);
    check("restart_done1", done_cnt, 1);
    wait_done(2, 400, "restart_done_timeout");
    check("restart_done2", done_cnt, 2);
    tick();

    // reset during the hold of word 0x10, with stop and start high
    clr();
    bus.start = 1; bus.dir = 0; bus.period = 4; bus.loop = 0;
    tick();
    bus.start = 0;
    wait_pv(5, 100, "rst_mid_timeout");
    check("rst_mid_word", pv_at(4), 8'h10);
    rst_n = 0; bus.stop = 1; bus.start = 1;
    tick();
    check("rst_mid_addr", bus.rom_addr, 0);
    check("rst_mid_pattern", bus.pattern, 0);
    check("rst_mid_flags", {bus.pattern_valid, bus.busy, bus.done}, 0);
    rst_n = 1; bus.stop = 0; bus.start = 0;
    tick(); tick();
    check("rst_mid_no_done", done_cnt, 0);

    // randomized traffic over random ROM contents
    for (int i = 0; i < 8; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.stop = ($urandom_range(0, 49) == 0);
      bus.dir = 1'($urandom);
      bus.loop = ($urandom_range(0, 2) != 0);
      bus.period = ($urandom_range(0, 9) == 0)
                   ? DIV_W'($urandom_range(0, 12))
                   : DIV_W'($urandom_range(0, 2));
      tick();
    end
    bus.start = 0; bus.stop = 1; rst_n = 1;
    tick();
    bus.stop = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
